// File: rtl/wb_commit.sv
`default_nettype none
// ============================================================================
// Module   : wb_commit
// Purpose  : Writeback commit stage merging a pipeline port (A) and a buffered
//            multicycle-unit port (B) into one register-file write port, with a
//            pending-write scoreboard and starvation protection for port B.
// Revision : 1.0 - initial release
// ============================================================================
module wb_commit #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_valid,
  input  logic [4:0]  a_dst,
  input  logic [63:0] a_data,
  output logic        a_stall,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_dst,
  input  logic [63:0] b_data,
  input  logic        iss_valid,
  input  logic [4:0]  iss_dst,
  output logic [31:0] busy,
  output logic        wvalid,
  output logic [4:0]  wa,
  output logic [63:0] wd
);

  localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam int c_STV_W = $clog2(STARVE_LIMIT + 1);

  logic [4:0]         r_fifo_dst  [FIFO_DEPTH];
  logic [63:0]        r_fifo_data [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic [c_STV_W-1:0] r_starve;
  logic [31:0]        r_busy;
  logic               r_wvalid;
  logic [4:0]         r_wa;
  logic [63:0]        r_wd;

  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic        w_a_win;
  logic [4:0]  w_head_dst;
  logic [63:0] w_head_data;
  logic [31:0] w_set;
  logic [31:0] w_clr;

  assign w_empty     = (r_count == '0);
  assign b_ready     = (r_count < c_CNT_W'(FIFO_DEPTH));
  assign a_stall     = (r_starve == c_STV_W'(STARVE_LIMIT));
  assign w_push      = b_valid & b_ready;
  assign w_head_dst  = r_fifo_dst[r_rd_ptr];
  assign w_head_data = r_fifo_data[r_rd_ptr];

  // A stalled port A yields to the FIFO head; otherwise port A has priority.
  assign w_a_win = a_valid & ~a_stall;
  assign w_pop   = ~w_empty & ~w_a_win;

  assign w_set = iss_valid ? (32'd1 << iss_dst) : 32'd0;
  assign w_clr = w_pop ? (32'd1 << w_head_dst) : 32'd0;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_dst[r_wr_ptr]  <= b_dst;
      r_fifo_data[r_wr_ptr] <= b_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve <= '0;
    end else if (w_empty || w_pop) begin
      r_starve <= '0;
    end else if (w_a_win) begin
      r_starve <= r_starve + c_STV_W'(1);
    end
  end

  // Set beats clear on the same index; register 0 is never tracked.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= ((r_busy & ~w_clr) | w_set) & ~32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wvalid <= 1'b0;
      r_wa     <= '0;
      r_wd     <= '0;
    end else if (w_a_win) begin
      r_wvalid <= (a_dst != 5'd0);
      if (a_dst != 5'd0) begin
        r_wa <= a_dst;
        r_wd <= a_data;
      end
    end else if (w_pop) begin
      r_wvalid <= (w_head_dst != 5'd0);
      if (w_head_dst != 5'd0) begin
        r_wa <= w_head_dst;
        r_wd <= w_head_data;
      end
    end else begin
      r_wvalid <= 1'b0;
    end
  end

  assign busy   = r_busy;
  assign wvalid = r_wvalid;
  assign wa     = r_wa;
  assign wd     = r_wd;

endmodule
`default_nettype wire
